// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and its consumer.
// The receiver drives data/valid; the consumer drives ready.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready output with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic      clk_25mhz,
  input  logic      resetn,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      busy,
  output logic      frame_err,
  output logic      overrun
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          rx_meta, rx_s, rx_prev;
  logic          start_edge;

  // Flops clear to 0, so the line must be seen high before a start can arm.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = ~rx_s & rx_prev;

  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      bus.data  <= '0;
      bus.valid <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (bus.valid && bus.ready) bus.valid <= 1'b0;
      case (state)
        IDLE: if (start_edge) begin
          state <= START;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        START: if (cnt == CNT_HALF) begin
          cnt <= '0;
          idx <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= DATA;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
        DATA: if (cnt == CNT_LAST) begin
          cnt        <= '0;
          shift[idx] <= rx_s;
          if (idx == 3'd7) state <= STOP;
          else             idx   <= idx + 3'd1;
        end else begin
          cnt <= cnt + CW'(1);
        end
        STOP: if (cnt == CNT_LAST) begin
          cnt   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
          // A pending byte being consumed this cycle frees the slot for the new one.
          if (!rx_s) begin
            frame_err <= 1'b1;
          end else if (!bus.valid || bus.ready) begin
            bus.data  <= shift;
            bus.valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// back-to-back, false-start, break, overrun and mid-frame reset sequences.
module tb_uart_rx;
  localparam int CPB = 217;

  logic clk_25mhz = 1'b0;
  logic resetn    = 1'b0;
  logic rx        = 1'b1;
  logic busy, frame_err, overrun;

  uart_rx_if bus();

  uart_rx #(.CLK_HZ(25000000), .BAUD(115200)) dut (
    .clk_25mhz (clk_25mhz),
    .resetn    (resetn),
    .rx        (rx),
    .bus       (bus.master),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int cyc = 0;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  // Monitor: log accepted beats, count flag pulses, note the cycle valid rises.
  logic [7:0] beat_data [256];
  int   beat_n = 0, ferr_n = 0, ovr_n = 0, last_rise = -1;
  logic valid_d = 1'b0;
  always @(negedge clk_25mhz) begin
    if (bus.valid && bus.ready) begin
      beat_data[beat_n] <= bus.data;
      beat_n <= beat_n + 1;
    end
    if (frame_err) ferr_n <= ferr_n + 1;
    if (overrun)   ovr_n  <= ovr_n + 1;
    if (bus.valid && !valid_d) last_rise <= cyc;
    valid_d <= bus.valid;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_25mhz);
    #1;
  endtask

  // Drives one frame starting at the current aligned point; t0 is the cycle
  // count just before edge 0 of the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    logic [9:0] f;
    f  = {stop, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      idle(CPB);
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    int         exp_beats;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int t0, b0, f0, o0;
    vecs[0] = '{8'h55, 8'h55, 1};
    vecs[1] = '{8'hA3, 8'hA3, 1};
    vecs[2] = '{8'h00, 8'h00, 1};
    vecs[3] = '{8'hFF, 8'hFF, 1};
    vecs[4] = '{8'h81, 8'h81, 1};
    vecs[5] = '{8'h6E, 8'h6E, 1};

    bus.ready = 1'b1;
    idle(3);
    check("reset data",      int'(bus.data),  0);
    check("reset valid",     int'(bus.valid), 0);
    check("reset busy",      int'(busy),      0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun",   int'(overrun),   0);
    resetn = 1'b1;
    idle(10);

    foreach (vecs[i]) begin
      b0 = beat_n; f0 = ferr_n; o0 = ovr_n;
      send_frame(vecs[i].din, 1'b1, t0);
      idle(20);
      check($sformatf("tbl%0d beats", i), beat_n - b0, vecs[i].exp_beats);
      check($sformatf("tbl%0d data", i), int'(beat_data[b0]), int'(vecs[i].exp_data));
      check($sformatf("tbl%0d valid edge", i), last_rise, t0 + 2064);
      check($sformatf("tbl%0d flags", i), (ferr_n - f0) + (ovr_n - o0), 0);
      check($sformatf("tbl%0d busy", i), int'(busy), 0);
    end

    // Back-to-back frames, no idle gap.
    b0 = beat_n; o0 = ovr_n;
    send_frame(8'hA3, 1'b1, t0);
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t0);
    idle(20);
    check("b2b beats",   beat_n - b0, 3);
    check("b2b data0",   int'(beat_data[b0]),   8'hA3);
    check("b2b data1",   int'(beat_data[b0+1]), 8'h00);
    check("b2b data2",   int'(beat_data[b0+2]), 8'hFF);
    check("b2b overrun", ovr_n - o0, 0);

    // False start: 50 low cycles then high.
    b0 = beat_n; f0 = ferr_n;
    rx = 1'b0;
    idle(20);
    check("false busy rise", int'(busy), 1);
    idle(30);
    rx = 1'b1;
    idle(300);
    check("false busy fall", int'(busy), 0);
    check("false beats",     beat_n - b0, 0);
    check("false frame_err", ferr_n - f0, 0);

    // Framing error followed by a held-low break.
    b0 = beat_n; f0 = ferr_n;
    send_frame(8'h3C, 1'b0, t0);
    idle(5 * CPB);
    check("break frame_err", ferr_n - f0, 1);
    check("break valid",     int'(bus.valid), 0);
    check("break busy",      int'(busy), 0);
    check("break beats",     beat_n - b0, 0);
    rx = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, t0);
    idle(20);
    check("post-break beats", beat_n - b0, 1);
    check("post-break data",  int'(beat_data[b0]), 8'h81);

    // Overrun with ready held low.
    bus.ready = 1'b0;
    b0 = beat_n; o0 = ovr_n;
    send_frame(8'h11, 1'b1, t0);
    idle(20);
    send_frame(8'h22, 1'b1, t0);
    idle(20);
    check("ovr valid",   int'(bus.valid), 1);
    check("ovr data",    int'(bus.data), 8'h11);
    check("ovr pulses",  ovr_n - o0, 1);
    bus.ready = 1'b1;
    idle(2);
    check("ovr drain beats", beat_n - b0, 1);
    check("ovr drain data",  int'(beat_data[b0]), 8'h11);
    check("ovr valid drop",  int'(bus.valid), 0);

    // Reset during data bit 3 of 0x96 (bits LSB first: 0,1,1,0).
    rx = 1'b0; idle(CPB);
    rx = 1'b0; idle(CPB);
    rx = 1'b1; idle(CPB);
    rx = 1'b1; idle(CPB);
    rx = 1'b0; idle(100);
    check("mid busy before rst", int'(busy), 1);
    resetn = 1'b0;
    #1;
    check("rst data",      int'(bus.data),  0);
    check("rst valid",     int'(bus.valid), 0);
    check("rst busy",      int'(busy),      0);
    check("rst frame_err", int'(frame_err), 0);
    check("rst overrun",   int'(overrun),   0);
    idle(3);
    resetn = 1'b1;
    b0 = beat_n;
    idle(3 * CPB);
    check("rst low-line busy",  int'(busy), 0);
    check("rst low-line beats", beat_n - b0, 0);
    rx = 1'b1;
    idle(20);
    send_frame(8'h5A, 1'b1, t0);
    idle(20);
    check("post-rst beats", beat_n - b0, 1);
    check("post-rst data",  int'(beat_data[b0]), 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
